// File: rtl/wb_commit_buffer.sv
// ---------------------------------------------------------------------------
// wb_commit_buffer
//
// Writeback commit buffer between the execution units and the integer
// register file. NCH producer channels offer writeback records through
// valid/ready handshakes. A round-robin arbiter grants one channel per cycle.
// Records that actually write a register (we=1, dest!=x0) go into an in-order
// circular FIFO of DEPTH entries. The FIFO drains one entry per cycle to the
// register file. An optional bypass search lets decode see results that are
// not committed yet.
//
// Optional feature macro: WB_BYPASS_EN
//   defined   -> bypass comparators are built
//   undefined -> look_hit / look_data are tied to zero (ports remain)
//
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   flush      in   synchronous clear of all buffered entries
//   in_valid   in   [NCH]        per-channel record valid
//   in_ready   out  [NCH]        per-channel grant (one-hot or zero)
//   in_dest    in   [NCH*5]      per-channel destination register
//   in_we      in   [NCH]        per-channel register write enable
//   in_data    in   [NCH*XLEN]   per-channel write data
//   out_valid  out               head entry valid
//   out_ready  in                register file accepts the head entry
//   out_dest   out  [5]          head destination register
//   out_data   out  [XLEN]       head data
//   look_addr  in   [NLOOK*5]    bypass source register addresses
//   look_hit   out  [NLOOK]      bypass match per port
//   look_data  out  [NLOOK*XLEN] bypass data per port
//   count      out  [clog2(DEPTH)+1] number of occupied entries
// ---------------------------------------------------------------------------
module wb_commit_buffer #(
    parameter int NCH   = 3,
    parameter int DEPTH = 4,
    parameter int XLEN  = 64,
    parameter int NLOOK = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic [NCH-1:0]          in_valid,
    output logic [NCH-1:0]          in_ready,
    input  logic [NCH*5-1:0]        in_dest,
    input  logic [NCH-1:0]          in_we,
    input  logic [NCH*XLEN-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4:0]              out_dest,
    output logic [XLEN-1:0]         out_data,
    input  logic [NLOOK*5-1:0]      look_addr,
    output logic [NLOOK-1:0]        look_hit,
    output logic [NLOOK*XLEN-1:0]   look_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [4:0]      mem_dest [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [RW-1:0]   rr;

    logic            full;
    logic            grant_any;
    logic [RW-1:0]   grant_idx;
    logic            hs;
    logic            enq;
    logic            deq;
    logic [4:0]      sel_dest;
    logic            sel_we;
    logic [XLEN-1:0] sel_data;

    // Channel index reached by stepping 'off' places from 'base', modulo NCH.
    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NCH) ? (s - NCH) : s;
    endfunction

    assign full = (count == CW'(DEPTH));

    // Round-robin search starting at rr; the first valid channel wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int off = 0; off < NCH; off++) begin
            if (!grant_any && in_valid[wrap_idx(int'(rr), off)]) begin
                grant_any = 1'b1;
                grant_idx = RW'(wrap_idx(int'(rr), off));
            end
        end
    end

    // Grant is withheld while full or flushing. Full is taken from the
    // registered count only, so a same-cycle dequeue cannot open the gate.
    always_comb begin
        in_ready = '0;
        if (grant_any && !full && !flush) begin
            in_ready = NCH'(1) << grant_idx;
        end
    end

    assign hs       = |in_ready;
    assign sel_dest = in_dest[int'(grant_idx)*5 +: 5];
    assign sel_we   = in_we[grant_idx];
    assign sel_data = in_data[int'(grant_idx)*XLEN +: XLEN];

    // Writes to x0 or with we=0 still complete the handshake but are dropped.
    assign enq = hs && sel_we && (sel_dest != 5'd0);

    assign out_valid = (count != '0) && !flush;
    assign deq       = out_valid && out_ready;

    // Head outputs are forced to zero when empty so stale storage never leaks.
    assign out_dest = out_valid ? mem_dest[head] : '0;
    assign out_data = out_valid ? mem_data[head] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rr    <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (hs) begin
                if (int'(grant_idx) == NCH - 1) begin
                    rr <= '0;
                end else begin
                    rr <= grant_idx + RW'(1);
                end
            end
            if (enq) begin
                tail <= tail + PW'(1);
            end
            if (deq) begin
                head <= head + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: every read path is qualified by count.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_dest[tail] <= sel_dest;
            mem_data[tail] <= sel_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        look_hit  = '0;
        look_data = '0;
        for (int k = 0; k < NLOOK; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!flush && (CW'(i) < count) &&
                    (look_addr[k*5 +: 5] != 5'd0) &&
                    (mem_dest[head + PW'(i)] == look_addr[k*5 +: 5])) begin
                    look_hit[k]               = 1'b1;
                    look_data[k*XLEN +: XLEN] = mem_data[head + PW'(i)];
                end
            end
        end
    end
`else
    logic unused_look;
    assign unused_look = ^look_addr;
    assign look_hit    = '0;
    assign look_data   = '0;
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// ---------------------------------------------------------------------------
// tb_wb_commit_buffer
//
// Directed bench for wb_commit_buffer with default parameters
// (NCH=3, DEPTH=4, XLEN=64, NLOOK=2). Inputs change 1 ns after a rising
// edge and outputs are sampled a few ns later, well clear of the next edge.
// Bypass expectations depend on whether WB_BYPASS_EN is defined.
// ---------------------------------------------------------------------------
module tb_wb_commit_buffer;

    localparam int NCH   = 3;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;
    localparam int NLOOK = 2;

    logic                   clk;
    logic                   reset_n;
    logic                   flush;
    logic [NCH-1:0]         in_valid;
    logic [NCH-1:0]         in_ready;
    logic [NCH*5-1:0]       in_dest;
    logic [NCH-1:0]         in_we;
    logic [NCH*XLEN-1:0]    in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [4:0]             out_dest;
    logic [XLEN-1:0]        out_data;
    logic [NLOOK*5-1:0]     look_addr;
    logic [NLOOK-1:0]       look_hit;
    logic [NLOOK*XLEN-1:0]  look_data;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;

    wb_commit_buffer #(
        .NCH  (NCH),
        .DEPTH(DEPTH),
        .XLEN (XLEN),
        .NLOOK(NLOOK)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dest  (in_dest),
        .in_we    (in_we),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_dest (out_dest),
        .out_data (out_data),
        .look_addr(look_addr),
        .look_hit (look_hit),
        .look_data(look_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic we,
                          input logic [4:0] dest, input logic [63:0] data);
        in_valid[ch]           = v;
        in_we[ch]              = we;
        in_dest[ch*5 +: 5]     = dest;
        in_data[ch*XLEN +: XLEN] = data;
    endtask

    task automatic clear_inputs();
        in_valid = '0;
        in_we    = '0;
        in_dest  = '0;
        in_data  = '0;
        flush    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        out_ready = 1'b0;
        look_addr = '0;
        clear_inputs();
        #12;

        // Reset state
        check("rst_count",     64'(count),     64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_dest",  64'(out_dest),  64'd0);
        check("rst_out_data",  out_data,       64'd0);
        check("rst_look_hit",  64'(look_hit),  64'd0);
        reset_n = 1'b1;

        // Single channel: x5=0x11 then x6=0x22
        tick();
        out_ready = 1'b1;
        set_ch(0, 1'b1, 1'b1, 5'd5, 64'h11);
        settle();
        check("sc_ready0", 64'(in_ready), 64'b001);
        tick();
        set_ch(0, 1'b1, 1'b1, 5'd6, 64'h22);
        settle();
        check("sc_valid1", 64'(out_valid), 64'd1);
        check("sc_dest1",  64'(out_dest),  64'd5);
        check("sc_data1",  out_data,       64'h11);
        check("sc_count1", 64'(count),     64'd1);
        check("sc_ready1", 64'(in_ready),  64'b001);
        tick();
        clear_inputs();
        settle();
        check("sc_dest2",  64'(out_dest),  64'd6);
        check("sc_data2",  out_data,       64'h22);
        check("sc_count2", 64'(count),     64'd1);
        tick();
        settle();
        check("sc_count3", 64'(count),     64'd0);
        check("sc_valid3", 64'(out_valid), 64'd0);

        // Round-robin after a fresh reset, all channels valid
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        for (int c = 0; c < NCH; c++) begin
            set_ch(c, 1'b1, 1'b1, 5'(c + 1), 64'h100 + 64'(c));
        end
        for (int n = 0; n < 6; n++) begin
            settle();
            check($sformatf("rr_grant%0d", n), 64'(in_ready), 64'(1) << (n % 3));
            check($sformatf("rr_count%0d", n), 64'(count), (n == 0) ? 64'd0 : 64'd1);
            if (n > 0) begin
                check($sformatf("rr_dest%0d", n), 64'(out_dest), 64'(((n - 1) % 3) + 1));
                check($sformatf("rr_data%0d", n), out_data, 64'h100 + 64'((n - 1) % 3));
            end
            tick();
        end
        clear_inputs();
        tick();
        settle();
        check("rr_drained", 64'(count), 64'd0);

        // Full: five offers with out_ready low, storage wraps around
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            set_ch(0, 1'b1, 1'b1, 5'(10 + n), 64'(n));
            settle();
            check($sformatf("full_ready%0d", n), 64'(in_ready), (n < 4) ? 64'b001 : 64'b000);
            check($sformatf("full_count%0d", n), 64'(count), 64'(n));
            tick();
        end
        out_ready = 1'b1;
        settle();
        check("full_no_comb_path", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b0;
        settle();
        check("full_count_after_deq", 64'(count),    64'd3);
        check("full_ready_after_deq", 64'(in_ready), 64'b001);
        check("full_head_dest",       64'(out_dest), 64'd11);
        check("full_head_data",       out_data,      64'd1);

        // Flush with three entries buffered
        flush = 1'b1;
        settle();
        check("flush_in_ready",  64'(in_ready),  64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        tick();
        clear_inputs();
        settle();
        check("flush_count", 64'(count),     64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);

        // Filtering: rr=1 here, so ch1 (we=0) goes first, then ch0 (dest=x0)
        set_ch(0, 1'b1, 1'b1, 5'd0, 64'hDEAD);
        set_ch(1, 1'b1, 1'b0, 5'd3, 64'hBEEF);
        settle();
        check("filt_grant_ch1", 64'(in_ready), 64'b010);
        tick();
        settle();
        check("filt_grant_ch0", 64'(in_ready),  64'b001);
        check("filt_count1",    64'(count),     64'd0);
        check("filt_valid1",    64'(out_valid), 64'd0);
        tick();
        clear_inputs();
        settle();
        check("filt_count2", 64'(count),     64'd0);
        check("filt_valid2", 64'(out_valid), 64'd0);

        // Bypass: x7=0xA (older) then x7=0xB (younger)
        look_addr = {5'd0, 5'd7};
        set_ch(0, 1'b1, 1'b1, 5'd7, 64'hA);
        settle();
        check("byp_not_visible", 64'(look_hit[0]), 64'd0);
        tick();
        set_ch(0, 1'b1, 1'b1, 5'd7, 64'hB);
        settle();
`ifdef WB_BYPASS_EN
        check("byp_hit_old",  64'(look_hit[0]),    64'd1);
        check("byp_data_old", look_data[63:0],     64'hA);
`else
        check("byp_hit_old",  64'(look_hit[0]),    64'd0);
        check("byp_data_old", look_data[63:0],     64'd0);
`endif
        tick();
        clear_inputs();
        settle();
        check("byp_count", 64'(count), 64'd2);
`ifdef WB_BYPASS_EN
        check("byp_hit_young",  64'(look_hit[0]), 64'd1);
        check("byp_data_young", look_data[63:0],  64'hB);
`else
        check("byp_hit_young",  64'(look_hit[0]), 64'd0);
        check("byp_data_young", look_data[63:0],  64'd0);
`endif
        check("byp_x0_hit",  64'(look_hit[1]),     64'd0);
        check("byp_x0_data", look_data[127:64],    64'd0);
        look_addr = {5'd9, 5'd7};
        settle();
        check("byp_x9_hit",  64'(look_hit[1]),     64'd0);
        check("byp_x9_data", look_data[127:64],    64'd0);

        // Asynchronous reset mid-cycle with two entries buffered
        reset_n = 1'b0;
        #1;
        check("arst_count",     64'(count),     64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_dest",  64'(out_dest),  64'd0);
        check("arst_out_data",  out_data,       64'd0);
        check("arst_look_hit",  64'(look_hit),  64'd0);
        check("arst_look_data", look_data[63:0], 64'd0);
        reset_n = 1'b1;
        tick();
        settle();
        check("arst_count_after", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
